// File: rtl/systolic_data_deskew_unit.sv
// Systolic output deskew: realigns lanes that leave a systolic array one
// enabled edge apart, so that every lane of a row appears on data_out together.
// Lane j is delayed by (MATRIX_WIDTH-1-j) enable-gated stages and then
// registered. A valid/last token pipeline runs alongside lane 0.
module systolic_data_deskew_unit #(
  parameter int unsigned MATRIX_WIDTH = 14,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             clear,
  input  logic                             valid_in,
  input  logic                             last_in,
  input  logic [MATRIX_WIDTH*DATA_WIDTH-1:0] data_in,
  output logic [MATRIX_WIDTH*DATA_WIDTH-1:0] data_out,
  output logic                             valid_out,
  output logic                             last_out,
  output logic                             busy,
  output logic [15:0]                      row_count
);

  // Token pipeline depth matches the delay seen by lane 0.
  localparam int Stages = int'(MATRIX_WIDTH) - 1;

  logic [Stages-1:0] vld_q;
  logic [Stages-1:0] lst_q;
  logic              valid_d;
  logic              last_d;
  logic [15:0]       row_count_d;

  // Data stages only move on enabled edges and hold while clear is applied.
  logic shift_en;
  assign shift_en = enable & ~clear;

  // Outputs pulse only on an enabled, non-clearing edge carrying a token.
  always_comb begin
    valid_d     = shift_en & vld_q[Stages-1];
    last_d      = shift_en & vld_q[Stages-1] & lst_q[Stages-1];
    row_count_d = row_count;
    if (clear) begin
      row_count_d = 16'd0;
    end else if (valid_d) begin
      row_count_d = row_count + 16'd1;
    end
  end

  // Valid/last token pipeline plus registered handshake outputs and row counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q     <= '0;
      lst_q     <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      row_count <= 16'd0;
    end else begin
      valid_out <= valid_d;
      last_out  <= last_d;
      row_count <= row_count_d;
      if (clear) begin
        vld_q <= '0;
        lst_q <= '0;
      end else if (enable) begin
        vld_q[0] <= valid_in;
        // last is qualified so a stray last_in never rides on a bubble
        lst_q[0] <= valid_in & last_in;
        for (int k = 1; k < Stages; k++) begin
          vld_q[k] <= vld_q[k-1];
          lst_q[k] <= lst_q[k-1];
        end
      end
    end
  end

  assign busy = |vld_q;

  for (genvar j = 0; j < int'(MATRIX_WIDTH); j++) begin : g_lane
    localparam int Depth = int'(MATRIX_WIDTH) - 1 - j;

    logic [DATA_WIDTH-1:0] lane_in;
    logic [DATA_WIDTH-1:0] out_q;

    assign lane_in = data_in[j*DATA_WIDTH +: DATA_WIDTH];
    assign data_out[j*DATA_WIDTH +: DATA_WIDTH] = out_q;

    if (Depth == 0) begin : g_direct
      // Last lane arrives aligned; only the output register applies.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_q <= '0;
        end else if (shift_en) begin
          out_q <= lane_in;
        end
      end
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] dly_q [Depth];

      // Delay line for this lane followed by its output register.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < Depth; k++) begin
            dly_q[k] <= '0;
          end
          out_q <= '0;
        end else if (shift_en) begin
          dly_q[0] <= lane_in;
          for (int k = 1; k < Depth; k++) begin
            dly_q[k] <= dly_q[k-1];
          end
          out_q <= dly_q[Depth-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_data_deskew_unit.sv
// Directed bench for the deskew unit at MATRIX_WIDTH=4, DATA_WIDTH=32.
module tb_systolic_data_deskew_unit;

  localparam int MW = 4;
  localparam int DW = 32;

  logic               clk;
  logic               rst;
  logic               enable;
  logic               clear;
  logic               valid_in;
  logic               last_in;
  logic [MW*DW-1:0]   data_in;
  logic [MW*DW-1:0]   data_out;
  logic               valid_out;
  logic               last_out;
  logic               busy;
  logic [15:0]        row_count;

  int checks = 0;
  int errors = 0;

  localparam logic [MW*DW-1:0] Z = '0;

  systolic_data_deskew_unit #(
    .MATRIX_WIDTH(MW),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clear    (clear),
    .valid_in (valid_in),
    .last_in  (last_in),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .last_out (last_out),
    .busy     (busy),
    .row_count(row_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             en;
    logic             clr;
    logic             vin;
    logic             lin;
    logic [MW*DW-1:0] din;
    logic             ev;
    logic             el;
    logic             eb;
    logic [15:0]      ec;
    logic             cd;
    logic [MW*DW-1:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [MW*DW-1:0] row(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  function automatic void add(input int en, input int clr, input int vin, input int lin,
                              input logic [MW*DW-1:0] din, input int ev, input int el,
                              input int eb, input int ec, input int cd,
                              input logic [MW*DW-1:0] ed);
    vec_t v;
    v.en  = (en != 0);
    v.clr = (clr != 0);
    v.vin = (vin != 0);
    v.lin = (lin != 0);
    v.din = din;
    v.ev  = (ev != 0);
    v.el  = (el != 0);
    v.eb  = (eb != 0);
    v.ec  = 16'(ec);
    v.cd  = (cd != 0);
    v.ed  = ed;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [MW*DW-1:0] act,
                     input logic [MW*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic clr, input logic vin, input logic lin,
                      input logic [MW*DW-1:0] din);
    enable   = en;
    clear    = clr;
    valid_in = vin;
    last_in  = lin;
    data_in  = din;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk($sformatf("%s valid_out", tag), {127'd0, valid_out}, Z);
    chk($sformatf("%s last_out", tag), {127'd0, last_out}, Z);
    chk($sformatf("%s busy", tag), {127'd0, busy}, Z);
    chk($sformatf("%s row_count", tag), {112'd0, row_count}, Z);
    chk($sformatf("%s data_out", tag), data_out, Z);
  endtask

  initial begin
    // args: en clr vin lin din | valid last busy count checkdata data
    // Aligned pair
    add(1, 1, 0, 0, Z,                 0, 0, 0, 0, 0, Z);
    add(1, 0, 1, 0, row(1, 0, 0, 0),   0, 0, 1, 0, 0, Z);
    add(1, 0, 1, 0, row(5, 2, 0, 0),   0, 0, 1, 0, 0, Z);
    add(1, 0, 0, 0, row(0, 6, 3, 0),   0, 0, 1, 0, 0, Z);
    add(1, 0, 0, 0, row(0, 0, 7, 4),   1, 0, 1, 1, 1, row(1, 2, 3, 4));
    add(1, 0, 0, 0, row(0, 0, 0, 8),   1, 0, 0, 2, 1, row(5, 6, 7, 8));
    add(1, 0, 0, 0, Z,                 0, 0, 0, 2, 0, Z);
    // Stall on e2, and a second stall while a row sits on data_out
    add(1, 1, 0, 0, Z,                 0, 0, 0, 0, 0, Z);
    add(1, 0, 1, 0, row(1, 0, 0, 0),   0, 0, 1, 0, 0, Z);
    add(1, 0, 1, 0, row(5, 2, 0, 0),   0, 0, 1, 0, 0, Z);
    add(0, 0, 0, 0, row(0, 6, 3, 0),   0, 0, 1, 0, 0, Z);
    add(1, 0, 0, 0, row(0, 6, 3, 0),   0, 0, 1, 0, 0, Z);
    add(1, 0, 0, 0, row(0, 0, 7, 4),   1, 0, 1, 1, 1, row(1, 2, 3, 4));
    add(0, 0, 0, 0, row(0, 0, 0, 8),   0, 0, 1, 1, 1, row(1, 2, 3, 4));
    add(1, 0, 0, 0, row(0, 0, 0, 8),   1, 0, 0, 2, 1, row(5, 6, 7, 8));
    add(1, 0, 0, 0, Z,                 0, 0, 0, 2, 0, Z);
    // Three back-to-back rows, last on the third
    add(1, 1, 0, 0, Z,                    0, 0, 0, 0, 0, Z);
    add(1, 0, 1, 0, row(11, 0, 0, 0),     0, 0, 1, 0, 0, Z);
    add(1, 0, 1, 0, row(21, 12, 0, 0),    0, 0, 1, 0, 0, Z);
    add(1, 0, 1, 1, row(31, 22, 13, 0),   0, 0, 1, 0, 0, Z);
    add(1, 0, 0, 1, row(0, 32, 23, 14),   1, 0, 1, 1, 1, row(11, 12, 13, 14));
    add(1, 0, 0, 0, row(0, 0, 33, 24),    1, 0, 1, 2, 1, row(21, 22, 23, 24));
    add(1, 0, 0, 0, row(0, 0, 0, 34),     1, 1, 0, 3, 1, row(31, 32, 33, 34));
    add(1, 0, 0, 1, Z,                    0, 0, 0, 3, 0, Z);
    // Clear mid-flight, then clear colliding with valid_in
    add(1, 1, 0, 0, Z,                 0, 0, 0, 0, 0, Z);
    add(1, 0, 1, 0, row(1, 0, 0, 0),   0, 0, 1, 0, 0, Z);
    add(1, 0, 0, 0, row(0, 2, 0, 0),   0, 0, 1, 0, 0, Z);
    add(1, 1, 0, 0, row(0, 0, 3, 0),   0, 0, 0, 0, 0, Z);
    add(1, 0, 0, 0, row(0, 0, 0, 4),   0, 0, 0, 0, 0, Z);
    add(1, 0, 0, 0, Z,                 0, 0, 0, 0, 0, Z);
    add(1, 0, 0, 0, Z,                 0, 0, 0, 0, 0, Z);
    add(1, 1, 1, 1, row(9, 0, 0, 0),   0, 0, 0, 0, 0, Z);
    add(1, 0, 0, 0, row(0, 10, 0, 0),  0, 0, 0, 0, 0, Z);
    add(1, 0, 0, 0, row(0, 0, 11, 0),  0, 0, 0, 0, 0, Z);
    add(1, 0, 0, 0, row(0, 0, 0, 12),  0, 0, 0, 0, 0, Z);
    add(1, 0, 0, 0, Z,                 0, 0, 0, 0, 0, Z);

    enable   = 1'b0;
    clear    = 1'b0;
    valid_in = 1'b0;
    last_in  = 1'b0;
    data_in  = Z;
    rst      = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].clr, vecs[i].vin, vecs[i].lin, vecs[i].din);
      chk($sformatf("vec%0d valid_out", i), {127'd0, valid_out}, {127'd0, vecs[i].ev});
      chk($sformatf("vec%0d last_out", i), {127'd0, last_out}, {127'd0, vecs[i].el});
      chk($sformatf("vec%0d busy", i), {127'd0, busy}, {127'd0, vecs[i].eb});
      chk($sformatf("vec%0d row_count", i), {112'd0, row_count}, {112'd0, vecs[i].ec});
      if (vecs[i].cd) chk($sformatf("vec%0d data_out", i), data_out, vecs[i].ed);
    end

    // Async reset with two rows in flight
    step(1'b1, 1'b1, 1'b0, 1'b0, Z);
    step(1'b1, 1'b0, 1'b1, 1'b0, row(1, 0, 0, 0));
    step(1'b1, 1'b0, 1'b1, 1'b0, row(5, 2, 0, 0));
    step(1'b1, 1'b0, 1'b0, 1'b0, row(0, 6, 3, 0));
    step(1'b1, 1'b0, 1'b0, 1'b0, row(0, 0, 7, 4));
    chk("pre-reset valid_out", {127'd0, valid_out}, {127'd0, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero("async reset");
    @(posedge clk);
    #1;
    chk_zero("held reset");
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0, row(9, 0, 0, 0));
    chk("post-reset e0 valid_out", {127'd0, valid_out}, Z);
    step(1'b1, 1'b0, 1'b0, 1'b0, row(0, 10, 0, 0));
    chk("post-reset e1 valid_out", {127'd0, valid_out}, Z);
    step(1'b1, 1'b0, 1'b0, 1'b0, row(0, 0, 11, 0));
    chk("post-reset e2 valid_out", {127'd0, valid_out}, Z);
    step(1'b1, 1'b0, 1'b0, 1'b0, row(0, 0, 0, 12));
    chk("post-reset e3 valid_out", {127'd0, valid_out}, {127'd0, 1'b1});
    chk("post-reset e3 data_out", data_out, row(9, 10, 11, 12));
    chk("post-reset e3 row_count", {112'd0, row_count}, {112'd0, 16'd1});

    // Counter wrap after 65536 emitted rows
    step(1'b1, 1'b1, 1'b0, 1'b0, Z);
    for (int i = 0; i < 65539; i++) begin
      step(1'b1, 1'b0, (i < 65536), 1'b0, Z);
      if (i == 65537) begin
        chk("wrap 65535 row_count", {112'd0, row_count}, {112'd0, 16'hFFFF});
      end
      if (i == 65538) begin
        chk("wrap 65536 row_count", {112'd0, row_count}, Z);
        chk("wrap 65536 valid_out", {127'd0, valid_out}, {127'd0, 1'b1});
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, Z);
    chk("wrap drained busy", {127'd0, busy}, Z);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_data_deskew_unit.md
SYSTOLIC_DATA_DESKEW_UNIT -- requirements
Module: systolic_data_deskew_unit

Interface
REQ-001 Parameter MATRIX_WIDTH, default 14: number of lanes (systolic array columns).
REQ-002 Parameter DATA_WIDTH, default 32: bits per lane element (accumulator result word).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  advance strobe; pipeline moves only on edges with enable=1.
REQ-006 clear  input  1  synchronous flush of all in-flight rows and the row counter.
REQ-007 valid_in  input  1  marks the edge on which lane 0 of a new row is sampled.
REQ-008 last_in  input  1  qualifies valid_in; marks the final row of a tile.
REQ-009 data_in  input  MATRIX_WIDTH x DATA_WIDTH  skewed lanes; lane j of a row arrives j enabled edges after lane 0.
REQ-010 data_out  output  MATRIX_WIDTH x DATA_WIDTH  realigned row, all lanes from the same row.
REQ-011 valid_out  output  1  data_out holds a newly aligned row this cycle.
REQ-012 last_out  output  1  aligned row is the final row of the tile.
REQ-013 busy  output  1  at least one valid row is in flight inside the unit.
REQ-014 row_count  output  16  number of rows emitted since reset/clear.

Function
REQ-015 Lane j SHALL pass through (MATRIX_WIDTH-1-j) enable-gated delay stages, then a registered output stage; lane MATRIX_WIDTH-1 has only the output register.
REQ-016 With enable held high, a row whose lane 0 is sampled at edge t SHALL appear complete on data_out after edge t+MATRIX_WIDTH-1.
REQ-017 valid_in and last_in SHALL travel a MATRIX_WIDTH-1 stage pipeline, aligned with lane 0, into the registered valid_out/last_out.
REQ-018 last_out SHALL be asserted only together with valid_out (last_in ignored when valid_in=0).
REQ-019 On an edge with enable=0: all delay stages and data_out hold; valid_out and last_out SHALL become 0; row_count holds.
REQ-020 The unit SHALL accept one row per enabled edge (full throughput, no backpressure, no bubbles inserted).
REQ-021 Lanes whose valid token is 0 still shift data; data_out content without valid_out is don't-care for consumers but SHALL be deterministic.
REQ-022 busy SHALL equal the OR of all internal valid-pipeline stages (excluding valid_out); combinational from registers only.
REQ-023 row_count SHALL increment by 1 on every edge that sets valid_out=1; wraps 0xFFFF -> 0x0000.
REQ-024 clear=1 on an edge SHALL zero all valid/last pipeline stages, valid_out, last_out and row_count, regardless of enable; data stages hold.
REQ-025 clear and valid_in on the same edge: clear wins, the incoming row is dropped.
REQ-026 A row partially inside the pipeline when clear asserts SHALL never produce valid_out.
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 rst=0 SHALL immediately (asynchronously) force all delay stages, data_out, valid/last pipeline, valid_out, last_out, row_count to 0; busy reads 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight rows; first row after release behaves as in REQ-016.
REQ-030 Release of rst SHALL be synchronous to clk in usage; the first active edge after release samples inputs normally.

Verification (MATRIX_WIDTH=4, DATA_WIDTH=32)
REQ-031 Aligned pair: rows A=[1,2,3,4], B=[5,6,7,8] driven skewed (edge0 L0=1; e1 L0=5,L1=2; e2 L1=6,L2=3; e3 L2=7,L3=4; e4 L3=8), valid_in at e0,e1, enable=1 -> after e3 data_out=[1,2,3,4], valid_out=1; after e4 [5,6,7,8], valid_out=1; after e5 valid_out=0; row_count=2.
REQ-032 Stall: same stimulus with enable=0 on e2 (inputs held) -> no shift on e2, valid_out=0 after e2; rows emerge one edge later, values unchanged.
REQ-033 Last flag: 3 back-to-back rows, last_in=1 on the third -> last_out=1 only on the third valid_out cycle; busy=1 from after e0 until the edge the third row emerges.
REQ-034 Clear mid-flight: row A lane 0 at e0, clear=1 at e2 -> no valid_out ever for A, row_count=0, busy=0 after e2.
REQ-035 Async reset: rst=0 asserted between edges with 2 rows in flight -> all outputs 0 before next edge; after release a new row [9,10,11,12] emerges exactly 3 edges after its lane 0.
REQ-036 Counter wrap: preload via 65536 emitted rows -> row_count returns to 0x0000 on the 65536th valid_out.
